// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register map,
// SRC valid bit position, configuration reset values and a byte-select helper.
package wb_irq_ctrl_pkg;

   // Word offsets selected by wb_adr_i[4:2]
   localparam logic [2:0] REG_PENDING  = 3'd0;
   localparam logic [2:0] REG_ENABLE   = 3'd1;
   localparam logic [2:0] REG_MODE     = 3'd2;
   localparam logic [2:0] REG_POLARITY = 3'd3;
   localparam logic [2:0] REG_SRC      = 3'd4;
   localparam logic [2:0] REG_SWSET    = 3'd5;

   localparam int SRC_VALID_BIT = 31;

   // Configuration reset values, truncated to NUM_IRQ bits by the user
   localparam logic [31:0] ENABLE_RST   = 32'h0000_0000;
   localparam logic [31:0] MODE_RST     = 32'h0000_0000;
   localparam logic [31:0] POLARITY_RST = 32'hFFFF_FFFF;

   // Expand the four byte selects into a 32-bit write mask
   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
      return m;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel front end: synchroniser chain, polarity correction
// and rising-edge detection of the active level.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic pol,      // polarity in effect this cycle
   input  logic pol_nxt,  // polarity that will be in effect next cycle
   output logic active,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   // Active level: POLARITY=1 passes the synchronised input, 0 inverts it
   assign active = sync_q[SYNC_STAGES-1] ^ ~pol;
   assign rise   = active & ~dly_q;

   // Shift the raw input in; the delay flop stores the current sample seen
   // through next cycle's polarity so a polarity write never fakes an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
         dly_q  <= sync_q[SYNC_STAGES-1] ^ ~pol_nxt;
      end
   end

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone-slave interrupt controller: per-channel enable/mode/polarity,
// W1C and software-set pending bits, registered combined interrupt and
// lowest-index priority encode.
module wb_irq_ctrl
   import wb_irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SRC_W       = 5
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [4:0]         wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   output logic [31:0]        wb_dat_o,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   output logic               wb_ack_o,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               int_o,
   output logic [SRC_W-1:0]   int_src_o
);

   logic [NUM_IRQ-1:0] pend_q, en_q, mode_q, pol_q;
   logic [NUM_IRQ-1:0] pend_nxt, en_nxt, mode_nxt, pol_nxt;
   logic [NUM_IRQ-1:0] lvl, rise, active, w1c, swset, msk, wd;
   logic [31:0]        wmask, wdat_m, rd_data;
   logic [SRC_W-1:0]   enc;
   logic [2:0]         reg_sel;
   logic               req, wr;
   logic               unused;

   assign req     = wb_cyc_i & wb_stb_i;
   assign wr      = req & wb_we_i & wb_ack_o;   // writes commit on the ack cycle
   assign reg_sel = wb_adr_i[4:2];
   assign wmask   = byte_mask(wb_sel_i);
   assign wdat_m  = wb_dat_i & wmask;
   assign msk     = wmask[NUM_IRQ-1:0];
   assign wd      = wdat_m[NUM_IRQ-1:0];
   assign active  = pend_q & en_q;
   assign unused  = ^{wb_adr_i[1:0], wmask, wdat_m};

   // Per-channel synchroniser and edge detector
   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
         .clk     (wb_clk_i),
         .rst     (wb_rst_i),
         .irq     (irq_i[i]),
         .pol     (pol_q[i]),
         .pol_nxt (pol_nxt[i]),
         .active  (lvl[i]),
         .rise    (rise[i])
      );
   end

   // Next-state of configuration registers and pending bits
   always_comb begin
      en_nxt   = en_q;
      mode_nxt = mode_q;
      pol_nxt  = pol_q;
      w1c      = '0;
      swset    = '0;
      if (wr) begin
         case (reg_sel)
            REG_PENDING:  w1c      = wd;
            REG_ENABLE:   en_nxt   = (en_q   & ~msk) | wd;
            REG_MODE:     mode_nxt = (mode_q & ~msk) | wd;
            REG_POLARITY: pol_nxt  = (pol_q  & ~msk) | wd;
            REG_SWSET:    swset    = wd;
            default: ;
         endcase
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (mode_q[i]) pend_nxt[i] = (rise[i] | swset[i]) ? 1'b1 : (w1c[i] ? 1'b0 : pend_q[i]);
         else           pend_nxt[i] = lvl[i];
      end
   end

   // Lowest set index of the active vector
   always_comb begin
      enc = '0;
      for (int i = NUM_IRQ-1; i >= 0; i--) if (active[i]) enc = SRC_W'(i);
   end

   // Read multiplexer; unused bits and unmapped offsets read zero
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_PENDING:  rd_data[NUM_IRQ-1:0] = pend_q;
         REG_ENABLE:   rd_data[NUM_IRQ-1:0] = en_q;
         REG_MODE:     rd_data[NUM_IRQ-1:0] = mode_q;
         REG_POLARITY: rd_data[NUM_IRQ-1:0] = pol_q;
         REG_SRC: begin
            rd_data[SRC_W-1:0]     = int_src_o;
            rd_data[SRC_VALID_BIT] = int_o;
         end
         default: ;
      endcase
   end

   // Bus handshake: one wait state, data only alongside ack
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= req & ~wb_ack_o;
         wb_dat_o <= (req & ~wb_ack_o & ~wb_we_i) ? rd_data : '0;
      end
   end

   // Registers, pending state and registered interrupt outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pend_q    <= '0;
         en_q      <= ENABLE_RST[NUM_IRQ-1:0];
         mode_q    <= MODE_RST[NUM_IRQ-1:0];
         pol_q     <= POLARITY_RST[NUM_IRQ-1:0];
         int_o     <= 1'b0;
         int_src_o <= '0;
      end else begin
         pend_q <= pend_nxt;
         en_q   <= en_nxt;
         mode_q <= mode_nxt;
         pol_q  <= pol_nxt;
         int_o  <= |active;
         if (|active) int_src_o <= enc;
      end
   end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Bench for wb_irq_ctrl: cycle model built from register-map and input-path
// rules, per-cycle output comparison, plus directed literal expectations.
module tb_wb_irq_ctrl;
   localparam int N = 8, S = 2, SW = 5;

   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0] sel = '0;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [N-1:0] irq = '0;
   logic [31:0] dat_o;
   logic ack, int_o;
   logic [SW-1:0] src;
   int n_chk = 0, n_pass = 0;
   logic chk_on = 1'b0;

   always #5 clk = ~clk;

   wb_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .SRC_W(SW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o),
      .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
      .irq_i(irq), .int_o(int_o), .int_src_o(src));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // ---------------- model ----------------
   // h[k] holds the raw input sampled k+1 edges ago
   logic [N-1:0] m_pend, m_en, m_mode, m_pol, h [0:S];
   logic m_ack, m_int;
   logic [SW-1:0] m_src;
   logic [31:0] m_dat;
   logic [N-1:0] x_now, x_prev, x_rise, x_act, x_mk, x_wd, n_pend, n_en, n_mode, n_pol;
   logic [SW-1:0] x_low;
   logic [31:0] x_rd;
   logic x_req, x_wr;

   always_comb begin
      x_req = cyc & stb;
      x_wr  = x_req & we & m_ack;
      for (int b = 0; b < N; b++) begin
         x_mk[b] = sel[b/8];
         x_wd[b] = sel[b/8] & wdat[b];
      end
      // a channel is active when its synchronised raw value equals its polarity
      x_now  = ~(h[S-1] ^ m_pol);
      x_prev = ~(h[S] ^ m_pol);
      x_rise = x_now & ~x_prev;
      x_act  = m_pend & m_en;
      x_low  = '0;
      for (int b = N-1; b >= 0; b--) if (x_act[b]) x_low = SW'(b);
      x_rd = 32'h0;
      case (adr[4:2])
         3'd0: x_rd = 32'(m_pend);
         3'd1: x_rd = 32'(m_en);
         3'd2: x_rd = 32'(m_mode);
         3'd3: x_rd = 32'(m_pol);
         3'd4: x_rd = {m_int, 26'h0, m_src};
         default: x_rd = 32'h0;
      endcase
      n_en   = (x_wr && adr[4:2] == 3'd1) ? ((m_en   & ~x_mk) | x_wd) : m_en;
      n_mode = (x_wr && adr[4:2] == 3'd2) ? ((m_mode & ~x_mk) | x_wd) : m_mode;
      n_pol  = (x_wr && adr[4:2] == 3'd3) ? ((m_pol  & ~x_mk) | x_wd) : m_pol;
      for (int b = 0; b < N; b++) begin
         if (!m_mode[b]) n_pend[b] = x_now[b];
         else if (x_rise[b] || (x_wr && adr[4:2] == 3'd5 && x_wd[b])) n_pend[b] = 1'b1;
         else if (x_wr && adr[4:2] == 3'd0 && x_wd[b]) n_pend[b] = 1'b0;
         else n_pend[b] = m_pend[b];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_pend <= '0; m_en <= '0; m_mode <= '0; m_pol <= '1;
         m_ack <= 1'b0; m_dat <= '0; m_int <= 1'b0; m_src <= '0;
         for (int k = 0; k <= S; k++) h[k] <= '0;
      end else begin
         m_ack <= x_req & ~m_ack;
         m_dat <= (x_req & ~m_ack & ~we) ? x_rd : 32'h0;
         m_int <= |x_act;
         if (|x_act) m_src <= x_low;
         m_pend <= n_pend; m_en <= n_en; m_mode <= n_mode; m_pol <= n_pol;
         h[0] <= irq;
         for (int k = S; k > 0; k--) h[k] <= h[k-1];
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("ack", 32'(ack), 32'(m_ack));
         check("dat_o", dat_o, m_dat);
         check("int_o", 32'(int_o), 32'(m_int));
         check("int_src_o", 32'(src), 32'(m_src));
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus(input logic w, input logic [2:0] r, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q);
      int t;
      @(negedge clk);
      adr = {r, 2'b00}; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!ack && t < 10);
      check("ack_latency", 32'(t), 32'd1);
      q = dat_o;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic [31:0] q;
      bus(1'b1, r, d, s, q);
   endtask

   task automatic rd(input string name, input logic [2:0] r, input logic [31:0] exp);
      logic [31:0] q;
      bus(1'b0, r, 32'h0, 4'hF, q);
      check(name, q, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      // 1: reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      check("rst_int_o", 32'(int_o), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_src", 32'(src), 32'd0);
      rst = 1'b0;
      rd("rst_pol", 3'd3, 32'h0000_00FF);
      rd("rst_en", 3'd1, 32'h0);
      rd("rst_pend", 3'd0, 32'h0);
      rd("rst_mode", 3'd2, 32'h0);
      rd("rst_src_reg", 3'd4, 32'h0);

      // 2: edge channel 2
      wr(3'd2, 32'h04);
      wr(3'd1, 32'h04);
      @(negedge clk); irq[2] = 1'b1;
      @(negedge clk); irq[2] = 1'b0;
      idle(2);
      check("edge_int_early", 32'(int_o), 32'd0);
      idle(1);
      check("edge_int", 32'(int_o), 32'd1);
      check("edge_src", 32'(src), 32'd2);
      rd("edge_pend", 3'd0, 32'h04);
      wr(3'd0, 32'h04);
      idle(2);
      check("edge_w1c_int", 32'(int_o), 32'd0);

      // 3: level channel 0, active low
      wr(3'd1, 32'h01);
      wr(3'd3, 32'hFE);
      idle(3);
      check("lvl_int", 32'(int_o), 32'd1);
      wr(3'd0, 32'h01);
      idle(1);
      check("lvl_w1c_int", 32'(int_o), 32'd1);
      rd("lvl_w1c_pend", 3'd0, 32'h01);
      @(negedge clk); irq[0] = 1'b1;
      idle(3);
      check("lvl_int_hold", 32'(int_o), 32'd1);
      idle(1);
      check("lvl_int_drop", 32'(int_o), 32'd0);

      // 4: priority, and no edge from a polarity change
      wr(3'd2, 32'hFF);
      wr(3'd3, 32'hFF);
      idle(4);
      rd("pol_no_edge", 3'd0, 32'h0);
      wr(3'd1, 32'hFF);
      @(negedge clk); irq[0] = 1'b0;
      idle(4);
      check("prio_idle_int", 32'(int_o), 32'd0);
      @(negedge clk); irq[5] = 1'b1; irq[3] = 1'b1;
      @(negedge clk); irq[5] = 1'b0; irq[3] = 1'b0;
      idle(4);
      check("prio_src3", 32'(src), 32'd3);
      rd("prio_src_reg3", 3'd4, 32'h8000_0003);
      wr(3'd0, 32'h08);
      idle(2);
      check("prio_src5", 32'(src), 32'd5);
      rd("prio_src_reg5", 3'd4, 32'h8000_0005);
      wr(3'd0, 32'h20);
      idle(2);
      check("prio_none_int", 32'(int_o), 32'd0);
      rd("prio_src_hold", 3'd4, 32'h0000_0005);

      // 5: set wins over a same-cycle W1C
      @(negedge clk); irq[1] = 1'b1;
      wr(3'd0, 32'h02);
      rd("collide_pend", 3'd0, 32'h02);
      @(negedge clk); irq[1] = 1'b0;
      wr(3'd0, 32'h02);
      rd("collide_clr", 3'd0, 32'h0);

      // byte selects, unimplemented bits and offsets
      wr(3'd1, 32'h0000_0000, 4'b1110);
      rd("sel_masked", 3'd1, 32'h0000_00FF);
      wr(3'd1, 32'hFFFF_FF0F);
      rd("upper_bits", 3'd1, 32'h0000_000F);
      rd("swset_reads0", 3'd5, 32'h0);
      wr(3'd7, 32'hFFFF_FFFF);
      rd("reg7_zero", 3'd7, 32'h0);
      rd("reg6_zero", 3'd6, 32'h0);

      // 6: software set on a disabled channel, then enable
      wr(3'd1, 32'h7F);
      wr(3'd5, 32'h80);
      rd("swset_pend", 3'd0, 32'h80);
      check("swset_int_off", 32'(int_o), 32'd0);
      wr(3'd1, 32'hFF);
      idle(2);
      check("swset_int_on", 32'(int_o), 32'd1);
      check("swset_src", 32'(src), 32'd7);

      // reset during a read
      @(negedge clk);
      adr = {3'd4, 2'b00}; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("rst_ack_drop", 32'(ack), 32'd0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      idle(1);
      check("rst2_int_o", 32'(int_o), 32'd0);
      check("rst2_src", 32'(src), 32'd0);
      rd("rst2_en", 3'd1, 32'h0);
      rd("rst2_pol", 3'd3, 32'h0000_00FF);
      rd("rst2_pend", 3'd0, 32'h0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
Parametrised Wishbone-slave interrupt controller. It is the next generation of the fixed-source controller feeding the PicoBlaze interrupt input.
- Aggregates NUM_IRQ asynchronous sources, each with per-channel enable, edge/level mode and polarity.
- Provides software set and write-1-to-clear on pending bits.
- Exposes a registered combined interrupt plus the encoded index of the highest-priority active source (lowest index wins).

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchroniser flops per source (2..3)
SRC_W, 5, width of int_src_o; must satisfy 2**SRC_W >= NUM_IRQ

Ports:
wb_clk_i  in  1  single clock; all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  5  byte address; [4:2] selects register
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_sel_i  in  4  byte selects; writes honour them
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_ack_o  out  1  single-cycle acknowledge
irq_i  in  NUM_IRQ  raw asynchronous interrupt sources
int_o  out  1  combined interrupt, registered
int_src_o  out  SRC_W  index of highest-priority active source, registered

Behaviour:
- Reset:
  - All registers, synchroniser and edge flops clear on a wb_rst_i-high clock edge.
  - ENABLE=0, MODE=0 (level), POLARITY=1 (active-high/rising), PENDING=0.
  - wb_ack_o=0, wb_dat_o=0, int_o=0, int_src_o=0.
  - Reset mid-bus-cycle drops ack; the master re-issues the access.
- Register map (word offset):
  - 0 PENDING: R; W1C.
  - 1 ENABLE: RW.
  - 2 MODE: RW; 1=edge, 0=level.
  - 3 POLARITY: RW.
  - 4 SRC: R; [SRC_W-1:0]=index, [31]=valid.
  - 5 SWSET: W; writes 1 to set PENDING, reads 0.
  - 6-7: read 0, writes ignored.
  - Bits >= NUM_IRQ always read 0 and ignore writes.
- Wishbone:
  - ack asserts the cycle after cyc&stb&!ack and lasts exactly one cycle, giving 1-wait-state access.
  - Write commits on the ack cycle.
  - wb_dat_o is valid with ack and 0 otherwise.
- Input path: per channel, a SYNC_STAGES flop chain, then XOR with POLARITY giving the active level, then one delay flop for edge detection.
- Level mode: PENDING[i] follows the synchronised active level each cycle. W1C and SWSET have no lasting effect.
- Edge mode:
  - PENDING[i] sets on an inactive-to-active transition or on SWSET[i].
  - It clears only on W1C.
  - Set wins over a same-cycle W1C.
- MODE/POLARITY change: the edge flop is updated with the new active level in the same cycle, so a change produces no spurious edge.
- Latency: irq_i edge to PENDING is SYNC_STAGES+1 cycles; PENDING to int_o/int_src_o is 1 cycle.
- active = PENDING & ENABLE.
  - int_o is registered |active.
  - int_src_o is the registered priority encode of active, lowest set index.
  - int_src_o holds its last value when active=0; SRC.valid=0 in that case.
- Simultaneous sources: all pend independently; int_src_o reports the lowest index. After W1C of that index, the next-lowest appears 1 cycle later.
- Disabled channels still latch PENDING. Enabling one with a pending bit raises int_o on the next cycle.

Decomposition:
- Package wb_irq_ctrl_pkg:
  - register offset constants REG_PENDING..REG_SWSET
  - SRC valid bit position (31)
  - reset values for ENABLE, MODE, POLARITY
- Sub-module irq_sync_edge, instantiated per channel with parameter SYNC_STAGES.
  - Inputs: raw irq, polarity.
  - Outputs: active level and one-cycle edge pulse.
- Top module holds the registers, Wishbone decode and priority encoder.

Test Plan:
1. Reset check -> after reset, reads are POLARITY=0x000000FF (NUM_IRQ=8), ENABLE=0, PENDING=0; int_o=0, wb_ack_o pulses exactly one cycle per access.
2. Edge channel: MODE=0x04, ENABLE=0x04, pulse irq_i[2] high for 1 cycle -> PENDING=0x04 after 3 cycles, int_o=1 and int_src_o=2 one cycle later. Write 0x04 to PENDING -> int_o=0 next cycle.
3. Level channel: ENABLE=0x01, POLARITY bit0=0, irq_i[0] low -> int_o=1. W1C has no effect while low. irq_i[0] high -> int_o=0 after 4 cycles.
4. Priority: ENABLE=0xFF, MODE=0xFF, edges on irq_i[5] and irq_i[3] same cycle -> int_src_o=3, SRC=0x80000003. W1C 0x08 -> int_src_o=5.
5. Collision: edge on irq_i[1] arrives in the same cycle as W1C 0x02 -> PENDING bit1 remains 1.
6. SWSET 0x80 with ENABLE bit7=0 -> PENDING=0x80, int_o=0. Set ENABLE=0x80 -> int_o=1 next cycle. Reset asserted during a read -> ack suppressed, all state cleared.
